// File: rtl/data_memory_pkg.sv
// Shared types and width helpers for the line-wide data memory.
package data_memory_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_e;

  localparam int unsigned WORD_BYTES = 4;

  // Bits needed to index one line of the array.
  function automatic int unsigned line_idx_w(input int unsigned mem_depth,
                                             input int unsigned line_words);
    return (mem_depth / line_words > 1) ? $clog2(mem_depth / line_words) : 1;
  endfunction

  // Byte-offset bits inside a line; these address bits are ignored.
  function automatic int unsigned line_off_w(input int unsigned line_words);
    return $clog2(line_words * WORD_BYTES);
  endfunction

  // Latency counter width.
  function automatic int unsigned cnt_w(input int unsigned latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// Line-organised storage: synchronous byte-strobed line write, combinational line read.
module data_memory_array
  import data_memory_pkg::*;
#(
  parameter int unsigned LINES      = 4096,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = 12
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [32*LINE_WORDS-1:0]     wdata,
  input  logic [4*LINE_WORDS-1:0]      wstrb,
  output logic [32*LINE_WORDS-1:0]     rdata
);

  localparam int unsigned LINE_W = 32 * LINE_WORDS;
  localparam int unsigned STRB_W = WORD_BYTES * LINE_WORDS;

  logic [LINE_W-1:0] mem_q [LINES];

  // Byte-granular line update; the array has no reset and is only cleared by the INIT sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned j = 0; j < STRB_W; j++) begin
        if (wstrb[j]) begin
          mem_q[idx][8*j +: 8] <= wdata[8*j +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/line_data_memory.sv
// Multi-cycle line-wide data memory with valid/ready request handshake and one-cycle response pulse.
module line_data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 16384,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 50,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     is_input_valid,
  input  logic [31:0]              addr,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [32*LINE_WORDS-1:0] din,
  input  logic [4*LINE_WORDS-1:0]  wstrb,
  output logic                     is_ready,
  output logic                     is_output_valid,
  output logic [32*LINE_WORDS-1:0] dout
);

  localparam int unsigned LINES  = MEM_DEPTH / LINE_WORDS;
  localparam int unsigned IDX_W  = line_idx_w(MEM_DEPTH, LINE_WORDS);
  localparam int unsigned OFF_W  = line_off_w(LINE_WORDS);
  localparam int unsigned CNT_W  = cnt_w(LATENCY);
  localparam int unsigned LINE_W = 32 * LINE_WORDS;
  localparam int unsigned STRB_W = WORD_BYTES * LINE_WORDS;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   init_idx_q, init_idx_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic [LINE_W-1:0]  dout_q, dout_d;
  logic               valid_q, valid_d;

  logic               arr_we;
  logic [IDX_W-1:0]   arr_idx;
  logic [LINE_W-1:0]  arr_wdata;
  logic [STRB_W-1:0]  arr_wstrb;
  logic [LINE_W-1:0]  arr_rdata;
  logic               unused_addr;

  // Only the line-index slice of addr matters; the rest is deliberately dropped.
  assign unused_addr = ^addr;

  data_memory_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .wstrb (arr_wstrb),
    .rdata (arr_rdata)
  );

  // Next-state, request latching and array access for the INIT/IDLE/BUSY/RESP sequence.
  // The op commits on the edge leaving RESP; the registered pulse and dout therefore land
  // in the following IDLE cycle, which keeps acceptance-to-pulse at exactly LATENCY edges.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    init_idx_d = init_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    arr_we     = 1'b0;
    arr_idx    = idx_q;
    arr_wdata  = wdata_q;
    arr_wstrb  = wstrb_q;

    unique case (state_q)
      S_INIT: begin
        if (INIT_ZERO != 0) begin
          arr_we     = 1'b1;
          arr_idx    = init_idx_q;
          arr_wdata  = '0;
          arr_wstrb  = '1;
          init_idx_d = init_idx_q + IDX_W'(1);
          if (init_idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (is_input_valid && (mem_read || mem_write)) begin
          op_d    = mem_write ? OP_WRITE : OP_READ;
          idx_d   = addr[OFF_W +: IDX_W];
          wdata_d = din;
          wstrb_d = wstrb;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
        if (op_q == OP_WRITE) begin
          arr_we = 1'b1;
        end else begin
          dout_d = arr_rdata;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control and request registers; reset restarts the sweep and drops any pending op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      op_q       <= OP_READ;
      cnt_q      <= '0;
      idx_q      <= '0;
      init_idx_q <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      init_idx_q <= init_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
    end
  end

  assign is_ready        = (state_q == S_IDLE);
  assign is_output_valid = valid_q;
  assign dout            = dout_q;

endmodule

// File: tb/tb_line_data_memory.sv
// Directed + randomized bench for line_data_memory with a byte-level reference model.
module tb_line_data_memory;

  localparam int unsigned LAT_A   = 4;
  localparam int unsigned DEPTH_A = 1024;
  localparam int unsigned BYTES_A = DEPTH_A * 4;
  localparam int unsigned DEPTH_B = 64;

  logic clk = 1'b0;
  logic reset_n;

  logic         a_valid, a_rd, a_wr, a_ready, a_ovalid;
  logic [31:0]  a_addr;
  logic [127:0] a_din, a_dout;
  logic [15:0]  a_strb;

  logic         b_valid, b_rd, b_wr, b_ready, b_ovalid;
  logic [31:0]  b_addr, b_din, b_dout;
  logic [3:0]   b_strb;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   ref_a [BYTES_A];
  logic [127:0] exp_dout_a;
  logic [31:0]  ref_b [DEPTH_B];
  logic [31:0]  exp_dout_b;

  always #5 clk = ~clk;

  line_data_memory #(
    .MEM_DEPTH  (DEPTH_A),
    .LINE_WORDS (4),
    .LATENCY    (LAT_A),
    .INIT_ZERO  (1)
  ) dut_a (
    .clk             (clk),
    .reset_n         (reset_n),
    .is_input_valid  (a_valid),
    .addr            (a_addr),
    .mem_read        (a_rd),
    .mem_write       (a_wr),
    .din             (a_din),
    .wstrb           (a_strb),
    .is_ready        (a_ready),
    .is_output_valid (a_ovalid),
    .dout            (a_dout)
  );

  line_data_memory #(
    .MEM_DEPTH  (DEPTH_B),
    .LINE_WORDS (1),
    .LATENCY    (1),
    .INIT_ZERO  (1)
  ) dut_b (
    .clk             (clk),
    .reset_n         (reset_n),
    .is_input_valid  (b_valid),
    .addr            (b_addr),
    .mem_read        (b_rd),
    .mem_write       (b_wr),
    .din             (b_din),
    .wstrb           (b_strb),
    .is_ready        (b_ready),
    .is_output_valid (b_ovalid),
    .dout            (b_dout)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte address wraps at the array size; the line starts at the 16-byte boundary below it.
  function automatic logic [127:0] ref_line_a(input logic [31:0] addr);
    logic [127:0] r;
    int unsigned base;
    base = ((addr % BYTES_A) / 16) * 16;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = ref_a[base + j];
    return r;
  endfunction

  task automatic ref_write_a(input logic [31:0] addr, input logic [127:0] din, input logic [15:0] strb);
    int unsigned base;
    base = ((addr % BYTES_A) / 16) * 16;
    for (int j = 0; j < 16; j++) if (strb[j]) ref_a[base + j] = din[8*j +: 8];
  endtask

  task automatic clear_models();
    for (int i = 0; i < BYTES_A; i++) ref_a[i] = 8'h00;
    for (int i = 0; i < DEPTH_B; i++) ref_b[i] = 32'h0;
    exp_dout_a = '0;
    exp_dout_b = '0;
  endtask

  task automatic init_wait_a();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (a_ready !== 1'b1 && n < 1000);
    chk("a_init_cycles", n, 256);
    chk("b_ready_after_init", b_ready, 1);
    clear_models();
  endtask

  task automatic wait_ready_a();
    int n;
    n = 0;
    @(negedge clk);
    while (a_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("a_ready_wait", a_ready, 1);
  endtask

  task automatic a_op(input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [127:0] din, input logic [15:0] strb);
    logic [31:0] r;
    wait_ready_a();
    a_valid = 1'b1; a_addr = addr; a_rd = rd; a_wr = wr; a_din = din; a_strb = strb;
    @(posedge clk); #1;
    if (wr) ref_write_a(addr, din, strb);
    else    exp_dout_a = ref_line_a(addr);
    for (int k = 0; k < LAT_A; k++) begin
      chk("a_busy_ready", a_ready, 0);
      chk("a_early_valid", a_ovalid, 0);
      r = $urandom;
      a_addr = r; a_din = {r, ~r, r, ~r}; a_strb = r[15:0]; a_rd = r[0]; a_wr = r[1];
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    chk("a_resp_valid", a_ovalid, 1);
    chk("a_resp_ready", a_ready, 1);
    chk("a_dout", a_dout, exp_dout_a);
    @(posedge clk); #1;
    chk("a_pulse_len", a_ovalid, 0);
  endtask

  task automatic b_step(input logic [31:0] addr, input logic rd, input logic wr,
                        input logic [31:0] din, input logic [3:0] strb);
    logic [31:0] r;
    int unsigned w;
    chk("b_ready_idle", b_ready, 1);
    b_valid = 1'b1; b_addr = addr; b_rd = rd; b_wr = wr; b_din = din; b_strb = strb;
    @(posedge clk); #1;
    w = (addr % (DEPTH_B * 4)) / 4;
    if (wr) begin
      for (int j = 0; j < 4; j++) if (strb[j]) ref_b[w][8*j +: 8] = din[8*j +: 8];
    end else begin
      exp_dout_b = ref_b[w];
    end
    chk("b_busy_ready", b_ready, 0);
    chk("b_early_valid", b_ovalid, 0);
    r = $urandom;
    b_addr = r; b_din = ~r; b_strb = r[3:0];
    @(posedge clk); #1;
    chk("b_resp_valid", b_ovalid, 1);
    chk("b_dout", b_dout, exp_dout_b);
    chk("b_resp_ready", b_ready, 1);
  endtask

  initial begin
    logic [31:0]  r, ra;
    logic [127:0] d;
    int unsigned  sel;

    reset_n = 1'b0;
    a_valid = 1'b1; a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_din = '0; a_strb = '0;
    b_valid = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_din = '0; b_strb = '0;
    clear_models();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", a_ready, 0);
    chk("rst_valid", a_ovalid, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_b_dout", b_dout, 0);

    // 1: INIT sweep holds off requests for MEM_DEPTH/LINE_WORDS cycles
    @(negedge clk);
    reset_n = 1'b1;
    init_wait_a();
    a_valid = 1'b0;
    a_op(32'h0, 1'b1, 1'b0, '0, '0);
    chk("t1_zero_line", a_dout, 0);

    // 2: full-line write, read back with nonzero offset
    a_op(32'h40, 1'b0, 1'b1, {4{32'hDEADBEEF}}, 16'hFFFF);
    a_op(32'h4C, 1'b1, 1'b0, '0, '0);
    chk("t2_line", a_dout, {4{32'hDEADBEEF}});

    // 3: partial strobe write touches word0 only
    a_op(32'h40, 1'b0, 1'b1, {4{32'h11223344}}, 16'h000F);
    a_op(32'h40, 1'b1, 1'b0, '0, '0);
    chk("t3_line", a_dout, {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h11223344});

    // 4: read+write is a write; neither is ignored
    d = {$urandom, $urandom, $urandom, $urandom};
    a_op(32'h80, 1'b1, 1'b1, d, 16'hFFFF);
    a_op(32'h80, 1'b1, 1'b0, '0, '0);
    chk("t4_both_write", a_dout, d);
    @(negedge clk);
    a_valid = 1'b1; a_rd = 1'b0; a_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("t4_neither_ready", a_ready, 1);
      chk("t4_neither_valid", a_ovalid, 0);
    end
    a_valid = 1'b0;

    // randomized traffic over a handful of lines with random upper address bits
    for (int i = 0; i < 40; i++) begin
      r   = $urandom;
      ra  = {r[31:12], 5'b0, 3'($urandom_range(0, 7)), r[3:0]};
      sel = $urandom_range(0, 2);
      d   = {$urandom, $urandom, $urandom, $urandom};
      a_op(ra, sel != 1, sel != 0, d, 16'($urandom));
    end

    // 5: reset during a pending write drops it and clears outputs
    a_op(32'h40, 1'b1, 1'b0, '0, '0);
    wait_ready_a();
    a_valid = 1'b1; a_rd = 1'b0; a_wr = 1'b1; a_addr = 32'h100;
    a_din = {$urandom, $urandom, $urandom, $urandom} | 128'h1; a_strb = 16'hFFFF;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", a_ovalid, 0);
    chk("t5_rst_ready", a_ready, 0);
    chk("t5_rst_dout", a_dout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    init_wait_a();
    a_op(32'h100, 1'b1, 1'b0, '0, '0);
    chk("t5_dropped_write", a_dout, 0);

    // 6: LATENCY=1 single-word instance, back-to-back requests every 2nd cycle
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      b_step({r[31:8], 6'(i), r[1:0]}, 1'b0, 1'b1, $urandom, 4'($urandom_range(1, 15)));
    end
    for (int i = 0; i < 10; i++) begin
      r = $urandom;
      b_step({r[31:8], 6'(i), r[1:0]}, 1'b1, 1'b0, '0, '0);
    end
    b_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_pulse_end", b_ovalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
